dmem_rr_arbiter: RTL
====================

// Module: dmem_rr_arbiter
// PURPOSE
//  Shares the single-port data SRAM between N core data (LSU) ports using the core's req/gnt/rvalid protocol.
//  Sits between the cores' data_*_o/data_*_i buses and the data memory in the multi-core soc top.
//  Round-robin fair arbitration; one access granted per cycle; fixed 1-cycle SRAM read latency.
// PARAMETERS
//  N_MST    2   number of requesting masters (2..8)
//  ADDR_W   32  byte address width
//  DATA_W   32  data width; BE width = DATA_W/8
// PORTS
//  clk_i          in   1            clock, rising edge
//  rst_i          in   1            reset, asynchronous, active-high
//  m_req_i        in   N_MST        per-master request
//  m_addr_i       in   N_MST*ADDR_W per-master byte address
//  m_we_i         in   N_MST        per-master write enable
//  m_be_i         in   N_MST*DATA_W/8 per-master byte enables
//  m_wdata_i      in   N_MST*DATA_W per-master write data
//  m_gnt_o        out  N_MST        one-hot grant, same cycle as request
//  m_rvalid_o     out  N_MST        response valid, cycle after grant (reads and writes)
//  m_rdata_o      out  DATA_W       read data, shared bus, qualified by m_rvalid_o
//  mem_req_o      out  1            SRAM access strobe
//  mem_addr_o     out  ADDR_W       SRAM byte address (muxed from winner)
//  mem_we_o       out  1            SRAM write enable
//  mem_be_o       out  DATA_W/8     SRAM byte enables
//  mem_wdata_o    out  DATA_W       SRAM write data
//  mem_rdata_i    in   DATA_W       SRAM read data, valid cycle after mem_req_o
// BEHAVIOUR
//  - Grant combinational: m_gnt_o = one-hot of first requesting master at or after prio_ptr, else 0.
//  - mem_req_o = |m_req_i; mem_* muxed from granted master; all mem_* = 0 when no request.
//  - prio_ptr register: on any grant to master k, prio_ptr <= (k+1) mod N_MST; unchanged if no grant.
//  - Reset: prio_ptr = 0 (master 0 highest), rvalid_q = 0, owner_q = 0, counters = 0.
//  - Response: owner_q/rvalid_q registered at grant; m_rvalid_o[owner_q] = rvalid_q in next cycle, others 0.
//  - m_rdata_o = mem_rdata_i passthrough (no extra register); writes also return rvalid, rdata don't-care.
//  - Back-to-back: new grant permitted every cycle, independent of pending rvalid (pipeline depth 1).
//  - A master holds req/addr/we/be/wdata stable until granted; arbiter never revokes a grant.
//  - Single requester: granted every cycle regardless of prio_ptr.
//  - All N requesting continuously: grants rotate 0,1,..,N-1,0..; no master waits more than N-1 cycles.
//  - Reset asserted mid-access: in-flight rvalid dropped; rvalid_q cleared immediately (async).
//  - Address/data widths passed unchanged; no address decode or range check in this block.
// CONFIGURATION
//  DMEM_ARB_PERF_EN defined: adds outputs perf_gnt_cnt_o[N_MST*32] (grants per master) and
//   perf_conflict_cnt_o[32] (cycles with >=2 requests); counters saturate at 2^32-1, cleared by reset.
//  Not defined: ports and counters absent; arbitration behaviour identical.
// STRUCTURE
//  dmem_arb_pkg: MST_IDX_W = $clog2(N_MST) localparam helper, mst_idx_t typedef, MEM_RD_LAT = 1,
//   perf counter width constant.
//  Sub-module rr_arbiter: generic N-way round-robin picker (req, ptr -> one-hot gnt, winner idx).
//  Top holds prio_ptr, owner_q, rvalid_q, request mux, response demux, optional perf counters.
// TESTING
//  1. Reset then m0 read 0x0000_0004 alone -> gnt[0] same cycle; rvalid[0] next cycle, rdata = mem[1].
//  2. m0 and m1 req every cycle, N_MST=2 -> gnt alternates 0,1,0,1; each rvalid goes to correct owner.
//  3. m1 write 0xDEADBEEF be=4'b0011 to 0x8 while m0 idle -> SRAM word 2 low half = 0xBEEF; rvalid[1].
//  4. N_MST=4, req=4'b1010 after grant to m1 -> next gnt = m3, then m1; masters 0,2 never granted.
//  5. Reset asserted the cycle after a grant -> no rvalid emitted; after release m0 wins first tie.
//  6. DMEM_ARB_PERF_EN: 10 cycles both requesting -> perf_gnt_cnt = 5/5, perf_conflict_cnt = 10.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory round-robin arbiter.
// No logic; holds the master-index type and the perf counter width.
package dmem_arb_pkg;
  localparam int N_MST_MAX  = 8;
  localparam int MST_IDX_W  = $clog2(N_MST_MAX);
  localparam int MEM_RD_LAT = 1;
  localparam int PERF_CNT_W = 32;

  typedef logic [MST_IDX_W-1:0] mst_idx_t;
endpackage

// File: rtl/rr_arbiter.sv
// Generic N-way round-robin picker: first requester at or after ptr wins.
// Latency: purely combinational, no state.
// Backpressure: none; a winner is reported whenever any request is present.
module rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N = 2
) (
  input  logic [N-1:0] req,
  input  mst_idx_t     ptr,
  output logic [N-1:0] gnt,
  output mst_idx_t     idx,
  output logic         vld
);

  // Outer loop walks priority order from ptr; the inner loop keeps every
  // vector index constant after unrolling.
  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    for (int i = 0; i < N; i++) begin
      for (int k = 0; k < N; k++) begin
        if (!vld && req[k] && (k == ((int'(ptr) + i) % N))) begin
          vld    = 1'b1;
          gnt[k] = 1'b1;
          idx    = mst_idx_t'(k);
        end
      end
    end
  end

endmodule

// File: rtl/dmem_rr_arbiter.sv
// Round-robin share of one single-port data SRAM among N_MST LSU ports (req/gnt/rvalid).
// Latency: grant same cycle as request, rvalid one cycle after grant; new grant every cycle.
// Backpressure: losers see gnt low and hold their request; DMEM_ARB_PERF_EN adds perf counters.
module dmem_rr_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int N_MST  = 2,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_MST-1:0]            m_req_i,
  input  logic [N_MST*ADDR_W-1:0]     m_addr_i,
  input  logic [N_MST-1:0]            m_we_i,
  input  logic [N_MST*DATA_W/8-1:0]   m_be_i,
  input  logic [N_MST*DATA_W-1:0]     m_wdata_i,
  output logic [N_MST-1:0]            m_gnt_o,
  output logic [N_MST-1:0]            m_rvalid_o,
  output logic [DATA_W-1:0]           m_rdata_o,
  output logic                        mem_req_o,
  output logic [ADDR_W-1:0]           mem_addr_o,
  output logic                        mem_we_o,
  output logic [DATA_W/8-1:0]         mem_be_o,
  output logic [DATA_W-1:0]           mem_wdata_o,
  input  logic [DATA_W-1:0]           mem_rdata_i
`ifdef DMEM_ARB_PERF_EN
  ,
  output logic [N_MST*32-1:0]         perf_gnt_cnt_o,
  output logic [31:0]                 perf_conflict_cnt_o
`endif
);

  localparam int BE_W = DATA_W / 8;

  mst_idx_t         prio_ptr;
  mst_idx_t         owner_q;
  logic             rvalid_q;
  logic [N_MST-1:0] gnt;
  mst_idx_t         win;
  logic             gnt_any;

  rr_arbiter #(.N(N_MST)) u_rr (
    .req (m_req_i),
    .ptr (prio_ptr),
    .gnt (gnt),
    .idx (win),
    .vld (gnt_any)
  );

  assign m_gnt_o   = gnt;
  assign mem_req_o = |m_req_i;
  assign m_rdata_o = mem_rdata_i;

  always_comb begin
    mem_addr_o  = '0;
    mem_we_o    = 1'b0;
    mem_be_o    = '0;
    mem_wdata_o = '0;
    for (int i = 0; i < N_MST; i++) begin
      if (gnt[i]) begin
        mem_addr_o  = m_addr_i[i*ADDR_W +: ADDR_W];
        mem_we_o    = m_we_i[i];
        mem_be_o    = m_be_i[i*BE_W +: BE_W];
        mem_wdata_o = m_wdata_i[i*DATA_W +: DATA_W];
      end
    end
  end

  // Pointer moves past the winner so it becomes lowest priority next cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_ptr <= '0;
      owner_q  <= '0;
      rvalid_q <= 1'b0;
    end else begin
      rvalid_q <= gnt_any;
      if (gnt_any) begin
        owner_q  <= win;
        prio_ptr <= (int'(win) == N_MST - 1) ? '0 : win + mst_idx_t'(1);
      end
    end
  end

  always_comb begin
    m_rvalid_o = '0;
    for (int i = 0; i < N_MST; i++) begin
      m_rvalid_o[i] = rvalid_q && (int'(owner_q) == i);
    end
  end

`ifdef DMEM_ARB_PERF_EN
  logic [PERF_CNT_W-1:0] gnt_cnt [N_MST];
  logic [PERF_CNT_W-1:0] conflict_cnt;

  // Counters stick at all-ones rather than wrapping.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < N_MST; i++) gnt_cnt[i] <= '0;
      conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < N_MST; i++) begin
        if (gnt[i] && (gnt_cnt[i] != '1)) gnt_cnt[i] <= gnt_cnt[i] + 1'b1;
      end
      if (($countones(m_req_i) >= 2) && (conflict_cnt != '1))
        conflict_cnt <= conflict_cnt + 1'b1;
    end
  end

  for (genvar g = 0; g < N_MST; g++) begin : g_perf
    assign perf_gnt_cnt_o[g*32 +: 32] = gnt_cnt[g];
  end
  assign perf_conflict_cnt_o = conflict_cnt;
`endif

endmodule
